// File: rtl/ctrl_pkg.sv
// Shared opcode, ALU-function and state definitions for the Mini SRC control sequencer.
package ctrl_pkg;

  localparam int unsigned OPC_W = 5;
  localparam int unsigned ALU_W = 5;

  localparam logic [OPC_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OPC_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPC_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPC_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPC_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPC_W-1:0] OP_BRX  = 5'b10010;
  localparam logic [OPC_W-1:0] OP_JR   = 5'b10100;
  localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

  localparam logic [ALU_W-1:0] ALU_NONE = 5'b00000;
  localparam logic [ALU_W-1:0] ALU_ADD  = 5'b00011;
  localparam logic [ALU_W-1:0] ALU_SUB  = 5'b00100;
  localparam logic [ALU_W-1:0] ALU_AND  = 5'b00101;
  localparam logic [ALU_W-1:0] ALU_OR   = 5'b00110;

  typedef enum logic [4:0] {
    ST_RST  = 5'd0,
    ST_T0   = 5'd1,
    ST_T1   = 5'd2,
    ST_T2   = 5'd3,
    ST_T3   = 5'd4,
    ST_T4   = 5'd5,
    ST_T5   = 5'd6,
    ST_T6   = 5'd7,
    ST_T7   = 5'd8,
    ST_HALT = 5'd9
  } state_e;

  typedef enum logic [3:0] {
    CL_RTYPE = 4'd0,
    CL_ITYPE = 4'd1,
    CL_LDI   = 4'd2,
    CL_LD    = 4'd3,
    CL_ST    = 4'd4,
    CL_BR    = 4'd5,
    CL_JR    = 4'd6,
    CL_NOP   = 4'd7,
    CL_HALT  = 4'd8
  } op_class_e;

  // Immediate forms reuse the register-form ALU function of the same name.
  function automatic logic [ALU_W-1:0] imm_alu(input logic [OPC_W-1:0] op);
    logic [ALU_W-1:0] f;
    f = ALU_NONE;
    case (op)
      OP_ADDI: f = ALU_ADD;
      OP_ANDI: f = ALU_AND;
      OP_ORI:  f = ALU_OR;
      default: f = ALU_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/ctrl_op_class.sv
// Combinational opcode classifier: groups opcodes that share a T-state sequence.
module ctrl_op_class
  import ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output op_class_e        op_class
);

  always_comb begin
    op_class = CL_NOP;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: op_class = CL_RTYPE;
      OP_ADDI, OP_ANDI, OP_ORI:      op_class = CL_ITYPE;
      OP_LDI:                        op_class = CL_LDI;
      OP_LD:                         op_class = CL_LD;
      OP_ST:                         op_class = CL_ST;
      OP_BRX:                        op_class = CL_BR;
      OP_JR:                         op_class = CL_JR;
      OP_HALT:                       op_class = CL_HALT;
      default:                       op_class = CL_NOP;
    endcase
  end

endmodule

// File: rtl/ctrl_seq.sv
// Hardwired Mini SRC control sequencer: fetch T0-T2, opcode-specific execute T3-T7,
// Moore-decoded datapath strobes, stop honoured at instruction boundaries.
module ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int STATE_W = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stop,
  input  logic [31:0] IR,
  input  logic        CON,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Read,
  output logic        Write,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Cout,
  output logic        CONin,
  output logic [4:0]  alu_op,
  output logic        run
);

  localparam int EW = $bits(state_e);

  logic [STATE_W-1:0] state_q, state_d;
  logic               stop_pend_q, stop_pend_d;
  state_e             cur_st, nxt_st;
  op_class_e          op_class;
  logic [OPC_W-1:0]   opcode;
  logic               last_st;
  logic               run_st;
  logic               unused_ir;

  assign opcode    = IR[31:27];
  assign unused_ir = ^IR[26:0];
  assign cur_st    = state_e'(state_q[EW-1:0]);
  assign run_st    = (cur_st != ST_RST) && (cur_st != ST_HALT);

  ctrl_op_class u_op_class (
    .opcode   (opcode),
    .op_class (op_class)
  );

  // Sequence length is decided by the class; last_st marks the instruction boundary.
  always_comb begin
    nxt_st  = cur_st;
    last_st = 1'b0;
    unique case (cur_st)
      ST_RST:  nxt_st = ST_T0;
      ST_T0:   nxt_st = ST_T1;
      ST_T1:   nxt_st = ST_T2;
      ST_T2: begin
        if (op_class == CL_HALT)     nxt_st = ST_HALT;
        else if (op_class == CL_NOP) last_st = 1'b1;
        else                         nxt_st = ST_T3;
      end
      ST_T3: begin
        if (op_class == CL_JR) last_st = 1'b1;
        else                   nxt_st = ST_T4;
      end
      ST_T4:   nxt_st = ST_T5;
      ST_T5: begin
        if ((op_class == CL_RTYPE) || (op_class == CL_ITYPE) || (op_class == CL_LDI))
          last_st = 1'b1;
        else
          nxt_st = ST_T6;
      end
      ST_T6: begin
        if (op_class == CL_BR) last_st = 1'b1;
        else                   nxt_st = ST_T7;
      end
      ST_T7:   last_st = 1'b1;
      ST_HALT: nxt_st = ST_HALT;
      default: nxt_st = ST_RST;
    endcase
    if (last_st) nxt_st = (stop || stop_pend_q) ? ST_HALT : ST_T0;
  end

  // A stop seen anywhere inside an instruction is held until its boundary.
  always_comb begin
    stop_pend_d = 1'b0;
    if (run_st && !last_st) stop_pend_d = stop_pend_q | stop;
    state_d = STATE_W'(nxt_st);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= STATE_W'(ST_RST);
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  always_comb begin
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0;
    MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0;
    Read = 1'b0; Write = 1'b0;
    Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0; Cout = 1'b0; CONin = 1'b0;
    alu_op = ALU_NONE;
    run = run_st;
    case (cur_st)
      ST_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
      end
      ST_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      ST_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      ST_T3: begin
        case (op_class)
          CL_RTYPE, CL_ITYPE: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          CL_LDI, CL_LD, CL_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          CL_BR: begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          CL_JR: begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          default: ;
        endcase
      end
      ST_T4: begin
        case (op_class)
          CL_RTYPE: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode; end
          CL_ITYPE: begin Cout = 1'b1; Zin = 1'b1; alu_op = imm_alu(opcode); end
          CL_LDI, CL_LD, CL_ST: begin Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD; end
          CL_BR: begin PCout = 1'b1; Yin = 1'b1; end
          default: ;
        endcase
      end
      ST_T5: begin
        case (op_class)
          CL_RTYPE, CL_ITYPE, CL_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CL_LD, CL_ST: begin Zlowout = 1'b1; MARin = 1'b1; end
          CL_BR: begin Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD; end
          default: ;
        endcase
      end
      ST_T6: begin
        case (op_class)
          CL_LD: begin Read = 1'b1; MDRin = 1'b1; end
          CL_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          CL_BR: begin Zlowout = 1'b1; PCin = CON; end
          default: ;
        endcase
      end
      ST_T7: begin
        case (op_class)
          CL_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CL_ST: Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule
